// File: rtl/board_update_scheduler_if.sv
// Bus bundle between the fallen-pieces board owner and its requesters.
// Also carries the working board, the display copy and the status outputs.
interface board_update_scheduler_if #(
  parameter int BLOCKS_WIDE  = 10,
  parameter int BLOCKS_HIGH  = 20,
  parameter int BITS_BLK_POS = 8,
  parameter int ROW_BITS     = 5
);
  logic                                 in_vblank;
  logic                                 clear_all_req;
  logic                                 clear_all_gnt;
  logic                                 lock_req;
  logic [BITS_BLK_POS-1:0]              lock_blk_1;
  logic [BITS_BLK_POS-1:0]              lock_blk_2;
  logic [BITS_BLK_POS-1:0]              lock_blk_3;
  logic [BITS_BLK_POS-1:0]              lock_blk_4;
  logic                                 lock_gnt;
  logic                                 row_req;
  logic [ROW_BITS-1:0]                  row_idx;
  logic                                 row_gnt;
  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0]   work_board;
  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0]   fallen_pieces;
  logic [BLOCKS_HIGH-1:0]               full_rows;
  logic                                 busy;
  logic                                 frame_committed;
  logic [15:0]                          lines_cleared;

  modport master (
    output in_vblank, clear_all_req, lock_req, lock_blk_1, lock_blk_2,
           lock_blk_3, lock_blk_4, row_req, row_idx,
    input  clear_all_gnt, lock_gnt, row_gnt, work_board, fallen_pieces,
           full_rows, busy, frame_committed, lines_cleared
  );

  modport slave (
    input  in_vblank, clear_all_req, lock_req, lock_blk_1, lock_blk_2,
           lock_blk_3, lock_blk_4, row_req, row_idx,
    output clear_all_gnt, lock_gnt, row_gnt, work_board, fallen_pieces,
           full_rows, busy, frame_committed, lines_cleared
  );
endinterface

// File: rtl/board_update_scheduler.sv
// Owns the fallen-pieces board: serialises clear/lock/row-remove updates on a
// working copy and commits it to the display copy only during vertical blanking.
module board_update_scheduler #(
  parameter int BLOCKS_WIDE  = 10,
  parameter int BLOCKS_HIGH  = 20,
  parameter int BITS_BLK_POS = 8,
  parameter int ROW_BITS     = 5
) (
  input logic                    clk,
  input logic                    rst_n,
  board_update_scheduler_if.slave bus
);
  localparam int CELLS = BLOCKS_WIDE * BLOCKS_HIGH;
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(BLOCKS_HIGH - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_LOCK  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_SCAN  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [1:0] OWN_CLR  = 2'd0;
  localparam logic [1:0] OWN_LOCK = 2'd1;
  localparam logic [1:0] OWN_ROW  = 2'd2;

  logic [2:0]                              state_r;
  logic [1:0]                              owner_r;
  logic [ROW_BITS-1:0]                     ptr_r;
  logic                                    dirty_r;
  logic [BLOCKS_HIGH-1:0][BLOCKS_WIDE-1:0] rows_r;
  logic [CELLS-1:0]                        disp_r;
  logic [BLOCKS_HIGH-1:0]                  full_r;
  logic                                    clr_gnt_r;
  logic                                    lock_gnt_r;
  logic                                    row_gnt_r;
  logic                                    busy_r;
  logic                                    commit_r;
  logic [15:0]                             lines_r;
  logic [CELLS-1:0]                        lock_board_s;

  // Positions outside the board are dropped rather than wrapped.
  function automatic logic [CELLS-1:0] set_cell(input logic [CELLS-1:0] board,
                                                input logic [BITS_BLK_POS-1:0] pos);
    logic [CELLS-1:0] res;
    res = board;
    if (int'(pos) < CELLS) begin
      res[pos] = 1'b1;
    end else begin
      res = board;
    end
    return res;
  endfunction

  // Working board with the four lock positions merged in.
  always_comb begin
    lock_board_s = rows_r;
    lock_board_s = set_cell(lock_board_s, bus.lock_blk_1);
    lock_board_s = set_cell(lock_board_s, bus.lock_blk_2);
    lock_board_s = set_cell(lock_board_s, bus.lock_blk_3);
    lock_board_s = set_cell(lock_board_s, bus.lock_blk_4);
  end

  // Scheduler FSM, board storage and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      owner_r    <= OWN_CLR;
      ptr_r      <= '0;
      dirty_r    <= 1'b0;
      rows_r     <= '0;
      disp_r     <= '0;
      full_r     <= '0;
      clr_gnt_r  <= 1'b0;
      lock_gnt_r <= 1'b0;
      row_gnt_r  <= 1'b0;
      busy_r     <= 1'b0;
      commit_r   <= 1'b0;
      lines_r    <= 16'd0;
    end else begin
      clr_gnt_r  <= 1'b0;
      lock_gnt_r <= 1'b0;
      row_gnt_r  <= 1'b0;
      commit_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (dirty_r && bus.in_vblank) begin
            disp_r   <= rows_r;
            dirty_r  <= 1'b0;
            commit_r <= 1'b1;
          end else if (bus.clear_all_req) begin
            state_r <= ST_CLR;
            owner_r <= OWN_CLR;
            busy_r  <= 1'b1;
          end else if (bus.lock_req) begin
            state_r <= ST_LOCK;
            owner_r <= OWN_LOCK;
            busy_r  <= 1'b1;
          end else if (bus.row_req) begin
            state_r <= ST_SHIFT;
            owner_r <= OWN_ROW;
            ptr_r   <= bus.row_idx;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CLR: begin
          rows_r    <= '0;
          full_r    <= '0;
          dirty_r   <= 1'b1;
          clr_gnt_r <= 1'b1;
          state_r   <= ST_DONE;
        end
        ST_LOCK: begin
          rows_r  <= lock_board_s;
          dirty_r <= 1'b1;
          ptr_r   <= '0;
          state_r <= ST_SCAN;
        end
        ST_SHIFT: begin
          // Rows above the removed one slide down one row per cycle.
          if (ptr_r > LAST_ROW) begin
            ptr_r   <= '0;
            state_r <= ST_SCAN;
          end else if (ptr_r != '0) begin
            rows_r[ptr_r] <= rows_r[ptr_r - 1'b1];
            ptr_r         <= ptr_r - 1'b1;
          end else begin
            rows_r[0] <= '0;
            lines_r   <= lines_r + 16'd1;
            dirty_r   <= 1'b1;
            ptr_r     <= '0;
            state_r   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          full_r[ptr_r] <= &rows_r[ptr_r];
          if (ptr_r == LAST_ROW) begin
            lock_gnt_r <= (owner_r == OWN_LOCK);
            row_gnt_r  <= (owner_r == OWN_ROW);
            state_r    <= ST_DONE;
          end else begin
            ptr_r <= ptr_r + 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clear_all_gnt   = clr_gnt_r;
  assign bus.lock_gnt        = lock_gnt_r;
  assign bus.row_gnt         = row_gnt_r;
  assign bus.work_board      = rows_r;
  assign bus.fallen_pieces   = disp_r;
  assign bus.full_rows       = full_r;
  assign bus.busy            = busy_r;
  assign bus.frame_committed = commit_r;
  assign bus.lines_cleared   = lines_r;
endmodule

// File: tb/tb_board_update_scheduler.sv
// Self-checking bench for board_update_scheduler: vector table plus grant scoreboard.
module tb_board_update_scheduler;
  localparam int W     = 10;
  localparam int H     = 20;
  localparam int CELLS = W * H;

  typedef struct {
    int         kind;      // 0 clear, 1 lock, 2 row
    int         cyc;
  } exp_t;

  typedef struct {
    int          kind;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [7:0]  b4;
    logic [4:0]  ridx;
    int          lat;
    logic [19:0] exp_full;
    int          exp_lines;
    bit          commit;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [CELLS-1:0] model_work = '0;
  logic [CELLS-1:0] model_disp = '0;
  vec_t vecs[6];

  board_update_scheduler_if bus ();

  board_update_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Every grant must match the head of the scoreboard in kind and cycle.
  always @(negedge clk) begin : gnt_monitor
    int   n;
    int   kind;
    exp_t e;
    n = int'(bus.clear_all_gnt) + int'(bus.lock_gnt) + int'(bus.row_gnt);
    if (n != 0) begin
      check("gnt_onehot", n, 1);
      kind = bus.clear_all_gnt ? 0 : (bus.lock_gnt ? 1 : 2);
      if (sb.size() == 0) begin
        check("gnt_unexpected", kind, -1);
      end else begin
        e = sb.pop_front();
        check("gnt_kind", kind, e.kind);
        check("gnt_cycle", cyc, e.cyc);
      end
    end
  end

  function automatic logic gnt_of(input int kind);
    return (kind == 0) ? bus.clear_all_gnt : ((kind == 1) ? bus.lock_gnt : bus.row_gnt);
  endfunction

  task automatic set_req(input int kind, input logic val);
    if (kind == 0) bus.clear_all_req = val;
    else if (kind == 1) bus.lock_req = val;
    else bus.row_req = val;
  endtask

  // Issue one request, expect its grant, and release it on the grant.
  task automatic run_op(input vec_t v);
    bit seen;
    bus.lock_blk_1 = v.b1;
    bus.lock_blk_2 = v.b2;
    bus.lock_blk_3 = v.b3;
    bus.lock_blk_4 = v.b4;
    bus.row_idx    = v.ridx;
    set_req(v.kind, 1'b1);
    sb.push_back('{v.kind, cyc + v.lat});
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) check("busy_after_accept", bus.busy, 1);
      if (gnt_of(v.kind)) begin
        seen = 1'b1;
        set_req(v.kind, 1'b0);
      end
    end
    check("gnt_seen", seen, 1);
    @(negedge clk);
    check("busy_after_gnt", bus.busy, 0);
  endtask

  task automatic model_apply(input vec_t v);
    if (v.kind == 0) begin
      model_work = '0;
    end else if (v.kind == 1) begin
      if (int'(v.b1) < CELLS) model_work[v.b1] = 1'b1;
      if (int'(v.b2) < CELLS) model_work[v.b2] = 1'b1;
      if (int'(v.b3) < CELLS) model_work[v.b3] = 1'b1;
      if (int'(v.b4) < CELLS) model_work[v.b4] = 1'b1;
    end else if (int'(v.ridx) < H) begin
      for (int r = int'(v.ridx); r > 0; r--) model_work[r*W +: W] = model_work[(r-1)*W +: W];
      model_work[0 +: W] = '0;
    end
  endtask

  // Raise vblank in an idle dirty cycle; the display copy follows one cycle later.
  task automatic commit_check;
    bus.in_vblank = 1'b1;
    @(negedge clk);
    check("commit_pulse", bus.frame_committed, 1);
    check("commit_fallen", bus.fallen_pieces, model_work);
    model_disp = model_work;
    @(negedge clk);
    check("commit_single", bus.frame_committed, 0);
    bus.in_vblank = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int   c;
    int   t;
    int   fcq[$];
    int   exp_fc[4];
    logic [2:0] done;

    vecs[0] = '{1, 8'd190, 8'd191, 8'd192, 8'd193, 5'd0,  22, 20'h00000, 0, 1'b1};
    vecs[1] = '{1, 8'd194, 8'd195, 8'd196, 8'd197, 5'd0,  22, 20'h00000, 0, 1'b0};
    vecs[2] = '{1, 8'd198, 8'd199, 8'd199, 8'd0,   5'd0,  22, 20'h80000, 0, 1'b0};
    vecs[3] = '{2, 8'd0,   8'd0,   8'd0,   8'd0,   5'd19, 41, 20'h00000, 1, 1'b0};
    vecs[4] = '{2, 8'd0,   8'd0,   8'd0,   8'd0,   5'd25, 22, 20'h00000, 1, 1'b1};
    vecs[5] = '{1, 8'd5,   8'd250, 8'd200, 8'd5,   5'd0,  22, 20'h00000, 1, 1'b0};

    bus.in_vblank     = 1'b1;
    bus.clear_all_req = 1'b0;
    bus.lock_req      = 1'b0;
    bus.row_req       = 1'b0;
    bus.lock_blk_1    = 8'd0;
    bus.lock_blk_2    = 8'd0;
    bus.lock_blk_3    = 8'd0;
    bus.lock_blk_4    = 8'd0;
    bus.row_idx       = 5'd0;

    // Reset, then idle with vblank high: nothing may move.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_fallen", bus.fallen_pieces, 0);
      check("rst_work", bus.work_board, 0);
      check("rst_full", bus.full_rows, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_commit", bus.frame_committed, 0);
      check("rst_lines", bus.lines_cleared, 0);
    end
    bus.in_vblank = 1'b0;

    // Table-driven single operations.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i]);
      model_apply(vecs[i]);
      check("vec_work", bus.work_board, model_work);
      check("vec_full", bus.full_rows, vecs[i].exp_full);
      check("vec_lines", bus.lines_cleared, vecs[i].exp_lines);
      check("vec_fallen_hold", bus.fallen_pieces, model_disp);
      if (vecs[i].commit) commit_check();
    end

    // Three simultaneous requests with a dirty board and vblank high.
    bus.lock_blk_1 = 8'd0;
    bus.lock_blk_2 = 8'd1;
    bus.lock_blk_3 = 8'd2;
    bus.lock_blk_4 = 8'd3;
    bus.row_idx    = 5'd0;
    bus.in_vblank  = 1'b1;
    bus.clear_all_req = 1'b1;
    bus.lock_req      = 1'b1;
    bus.row_req       = 1'b1;
    c = cyc;
    sb.push_back('{0, c + 3});
    sb.push_back('{1, c + 27});
    sb.push_back('{2, c + 51});
    exp_fc = '{c + 1, c + 5, c + 29, c + 53};
    done = 3'b000;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.frame_committed) fcq.push_back(cyc);
      if (bus.clear_all_gnt) begin bus.clear_all_req = 1'b0; done[0] = 1'b1; end
      if (bus.lock_gnt)      begin bus.lock_req = 1'b0;      done[1] = 1'b1; end
      if (bus.row_gnt)       begin bus.row_req = 1'b0;       done[2] = 1'b1; end
    end
    check("sim_all_granted", done, 3'b111);
    check("sim_commit_count", fcq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("sim_commit_cycle", (i < fcq.size()) ? fcq[i] : -1, exp_fc[i]);
    end
    check("sim_work", bus.work_board, 0);
    check("sim_fallen", bus.fallen_pieces, 0);
    check("sim_lines", bus.lines_cleared, 2);
    check("sim_busy", bus.busy, 0);
    bus.in_vblank = 1'b0;
    model_work = '0;
    model_disp = '0;

    // Reset in the middle of a lock's row scan: operation aborted, no grant.
    run_op('{1, 8'd50, 8'd50, 8'd50, 8'd50, 5'd0, 22, 20'h0, 2, 1'b1});
    model_work[50] = 1'b1;
    commit_check();
    check("pre_rst_fallen", bus.fallen_pieces, model_work);
    bus.lock_blk_1 = 8'd60;
    bus.lock_req   = 1'b1;
    t = cyc;
    repeat (10) @(negedge clk);
    check("scan_busy", bus.busy, 1);
    rst_n = 1'b0;
    bus.lock_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_work", bus.work_board, 0);
    check("abort_fallen", bus.fallen_pieces, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_full", bus.full_rows, 0);
    check("abort_lines", bus.lines_cleared, 0);
    repeat (30) @(negedge clk);
    check("abort_no_gnt", bus.lock_gnt, 0);
    check("abort_elapsed_busy", bus.busy, 0);
    check("sb_drained", sb.size(), 0);
    if (cyc - t < 30) check("abort_span", cyc - t, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/board_update_scheduler.md
Name: board_update_scheduler

Overview:
- Owns the fallen-pieces board and arbitrates write access among three requesters:
  - the piece-lock logic;
  - the row-clear logic;
  - the game-reset logic.
- Keeps a working copy for game logic and collision checks.
- Publishes a display copy to the VGA display block, updated only during vertical blanking so that no frame shows a half-applied update.

Parameters:
- BLOCKS_WIDE, 10, board width in blocks.
- BLOCKS_HIGH, 20, board height in blocks.
- BITS_BLK_POS, 8, width of a block position index, equal to x + y*BLOCKS_WIDE with row 0 at the top.
- ROW_BITS, 5, width of the row index; must be at least clog2(BLOCKS_HIGH).

Ports:
- clk  in  1  pixel/system clock.
- rst_n  in  1  synchronous active-low reset.
- in_vblank  in  1  high while the display counter_y is at or beyond SCREEN_HEIGHT.
- clear_all_req  in  1  request to zero the board.
- clear_all_gnt  out  1  one-cycle completion pulse for clear_all_req.
- lock_req  in  1  request to lock the current piece into the board.
- lock_blk_1..lock_blk_4  in  BITS_BLK_POS each  positions to set.
- lock_gnt  out  1  one-cycle completion pulse for lock_req.
- row_req  in  1  request to remove a row.
- row_idx  in  ROW_BITS  row to remove.
- row_gnt  out  1  one-cycle completion pulse for row_req.
- work_board  out  BLOCKS_WIDE*BLOCKS_HIGH  working board, updated immediately.
- fallen_pieces  out  BLOCKS_WIDE*BLOCKS_HIGH  display copy, updated only at commit.
- full_rows  out  BLOCKS_HIGH  bit r set when row r of work_board is fully occupied.
- busy  out  1  high whenever state is not IDLE.
- frame_committed  out  1  one-cycle pulse when fallen_pieces is loaded.
- lines_cleared  out  16  count of valid row removals, wraps at 0xFFFF.

Behaviour:
- Reset (rst_n low at a clk edge):
  - all outputs and the state are cleared: state = IDLE, boards = 0, full_rows = 0, counter = 0, all gnt = 0, dirty = 0.
  - Reset mid-operation aborts the operation; no gnt is issued.
- Row r occupies bits [r*BLOCKS_WIDE +: BLOCKS_WIDE].
- States: IDLE, CLR_ALL, LOCK, SHIFT, SCAN, DONE. An internal owner register records which requester's gnt fires in DONE.
- IDLE, priority highest first (one action per cycle):
  1. Commit, if dirty and in_vblank: fallen_pieces <= work_board, dirty <= 0, frame_committed = 1 next cycle. Stay in IDLE.
  2. clear_all_req -> CLR_ALL.
  3. lock_req -> LOCK.
  4. row_req -> SHIFT, with ptr <= row_idx latched.
- CLR_ALL: work_board <= 0, full_rows <= 0, dirty <= 1 -> DONE.
- LOCK:
  - Sets the four addressed bits in one cycle; duplicate positions are harmless.
  - Positions >= BLOCKS_WIDE*BLOCKS_HIGH are ignored.
  - dirty <= 1; ptr <= 0 -> SCAN.
- SHIFT:
  - If the latched row >= BLOCKS_HIGH: no change, counter not incremented -> SCAN, ptr <= 0.
  - Otherwise, one row per cycle:
    - while ptr > 0: row[ptr] <= row[ptr-1], ptr <= ptr-1;
    - at ptr == 0: row[0] <= 0, lines_cleared++, dirty <= 1 -> SCAN, ptr <= 0.
- SCAN: full_rows[ptr] <= AND of row ptr; ptr++. After row BLOCKS_HIGH-1 -> DONE.
- DONE: the owner's gnt is high for this single cycle -> IDLE.
- Handshake:
  - A requester holds req until its gnt.
  - A req still high in the cycle after gnt is a new request.
  - A started operation always completes even if req drops.
  - Request inputs are sampled only in IDLE.
- Latency, with T = IDLE cycle that accepts the request and H = BLOCKS_HIGH:
  - clear_all_gnt at T+2.
  - lock_gnt at T+H+2.
  - row_gnt at T+k+H+2 for a valid row k.
  - row_gnt at T+H+2 for an invalid row.
- Commit:
  - A commit never occurs outside in_vblank or while busy.
  - A pending commit waits for the next IDLE cycle with in_vblank high.
  - A dirty board left over when vblank ends carries to the next frame.
- Simultaneous requests are served by priority order. A lower-priority requester waits, with its gnt low, until it is selected.

Test Plan:
- Reset, then rst_n = 1 with no requests:
  - fallen_pieces = 0, full_rows = 0, busy = 0, all gnt = 0;
  - no frame_committed, even with in_vblank = 1.
- lock_req with blocks 190, 191, 192, 193 and in_vblank = 0:
  - lock_gnt pulses exactly 22 cycles after acceptance;
  - work_board bits 190-193 set, fallen_pieces unchanged;
  - raising in_vblank gives frame_committed 1 cycle later, with matching fallen_pieces.
- Fill row 19 (bits 190-199) via three locks:
  - full_rows = 0x80000.
- Then row_req with row_idx = 19, and bit 0 set beforehand:
  - row_gnt at T+41;
  - bit 10 set, bit 0 clear, row 19 equal to the former row 18;
  - full_rows = 0, lines_cleared = 1.
- row_req with row_idx = 25:
  - row_gnt at T+22;
  - board and lines_cleared unchanged.
- clear_all_req, lock_req and row_req asserted in the same cycle:
  - order of service is clear_all_gnt, then lock_gnt, then row_gnt, never overlapping;
  - with in_vblank = 1 and dirty, a commit is interleaved in IDLE before each next grant.
- rst_n low during SCAN of a lock:
  - no lock_gnt;
  - boards zero, busy = 0 the cycle after.
